sseg_scan_ctrl: RTL

//  Time-multiplexed scan controller for the Elbert V2 common-anode 7-segment display (3 digits).

---
 rtl/sseg_pkg.sv | 37 +++
 rtl/hex2sseg.sv | 36 +++
 rtl/sseg_scan_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/sseg_pkg.sv
// Shared types and helpers for the 7-segment scan controller.
package sseg_pkg;

  // Scan sequencer states.
  typedef enum logic [1:0] {
    StIdle,
    StBlank,
    StShow
  } scan_state_e;

  // All segments off (active-low).
  localparam logic [7:0] SsegOff = 8'hFF;

  // Upper bound on the digit count the helpers below can handle.
  localparam int unsigned MaxDigits = 8;

  // Leading-zero blanking mask: bit i set when digit i (i > 0) and every higher
  // digit hold hex 0 with the decimal point off. Digit 0 is never blanked.
  function automatic logic [MaxDigits-1:0] lzb_mask(
    input logic [MaxDigits-1:0][3:0] live_hex,
    input logic [MaxDigits-1:0]      live_dp,
    input int unsigned               n_digits
  );
    logic [MaxDigits-1:0] mask;
    logic                 all_zero;
    mask     = '0;
    all_zero = 1'b1;
    for (int i = MaxDigits - 1; i >= 0; i--) begin
      if (i < int'(n_digits)) begin
        all_zero = all_zero && (live_hex[i] == 4'h0) && !live_dp[i];
        mask[i]  = all_zero && (i != 0);
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/hex2sseg.sv
// Combinational hex to 7-segment decoder, active-low segments.
// sseg_o[7] passes dp_i straight through; sseg_o[6:0] = a..g.
module hex2sseg (
  input  logic [3:0] hex_i,
  input  logic       dp_i,
  output logic [7:0] sseg_o
);

  logic [6:0] seg;

  // Segment lookup, a in bit 6 down to g in bit 0.
  always_comb begin
    seg = 7'h7F;
    unique case (hex_i)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
    endcase
  end

  assign sseg_o = {dp_i, seg};

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Host writes land in shadow registers and are committed to the live set at
// frame boundaries so a frame never shows a mix of old and new digits.
module sseg_scan_ctrl #(
  parameter int unsigned N_DIGITS     = 3,
  parameter int unsigned PRESCALE     = 12000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned IDX_W        = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                lzb,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [3:0]          wr_hex,
  input  logic                wr_dp,
  output logic [7:0]          sseg,
  output logic [N_DIGITS-1:0] an,
  output logic                frame_tick,
  output logic                pending
);

  import sseg_pkg::*;

  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned DigW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [CntW-1:0] CntLast   = CntW'(PRESCALE - 1);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [DigW-1:0] DigLast   = DigW'(N_DIGITS - 1);

  scan_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [DigW-1:0] digit_q, digit_d;

  logic [N_DIGITS-1:0][3:0] shadow_hex_q, shadow_hex_d;
  logic [N_DIGITS-1:0]      shadow_dp_q, shadow_dp_d;
  logic [N_DIGITS-1:0][3:0] live_hex_q, live_hex_d;
  logic [N_DIGITS-1:0]      live_dp_q, live_dp_d;
  logic                     pending_q, pending_d;

  logic [N_DIGITS-1:0] an_q, an_d;
  logic [7:0]          sseg_q, sseg_d;
  logic                tick_q, tick_d;

  logic                frame_end;
  logic                commit;
  logic [N_DIGITS-1:0] wr_hit;

  logic [3:0]           sel_hex;
  logic                 sel_dp;
  logic [7:0]           dec_sseg;
  logic [MaxDigits-1:0][3:0] hex_pad;
  logic [MaxDigits-1:0] dp_pad;
  logic [MaxDigits-1:0] blank_mask;
  logic                 sel_blank;

  // Scan sequencer: slot counter spans blank plus show, digit advances per slot.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    digit_d   = digit_q;
    frame_end = 1'b0;
    if (!enable) begin
      state_d = StIdle;
      cnt_d   = '0;
      digit_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StBlank;
          cnt_d   = '0;
          digit_d = '0;
        end
        StBlank: begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == BlankLast) begin
            state_d = StShow;
          end
        end
        StShow: begin
          if (cnt_q == CntLast) begin
            state_d = StBlank;
            cnt_d   = '0;
            if (digit_q == DigLast) begin
              digit_d   = '0;
              frame_end = 1'b1;
            end else begin
              digit_d = digit_q + DigW'(1);
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
          digit_d = '0;
        end
      endcase
    end
  end

  // With no frame running there is no boundary to wait for, so commit at once.
  assign commit = frame_end || ((state_q == StIdle) && pending_q);
  assign tick_d = frame_end;

  // Decode the write strobe; out-of-range indices hit nothing.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      wr_hit[i] = wr_en && (wr_idx == IDX_W'(i));
    end
  end

  // Shadow/live update; a commit samples the pre-write shadow contents.
  always_comb begin
    shadow_hex_d = shadow_hex_q;
    shadow_dp_d  = shadow_dp_q;
    live_hex_d   = live_hex_q;
    live_dp_d    = live_dp_q;
    pending_d    = pending_q;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (wr_hit[i]) begin
        shadow_hex_d[i] = wr_hex;
        shadow_dp_d[i]  = wr_dp;
      end
    end
    if (commit) begin
      live_hex_d = shadow_hex_q;
      live_dp_d  = shadow_dp_q;
      pending_d  = 1'b0;
    end
    // A write landing on the commit edge is still outstanding afterwards.
    if (|wr_hit) begin
      pending_d = 1'b1;
    end
  end

  // Select the live digit currently being scanned.
  always_comb begin
    sel_hex = 4'h0;
    sel_dp  = 1'b0;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (digit_q == DigW'(i)) begin
        sel_hex = live_hex_q[i];
        sel_dp  = live_dp_q[i];
      end
    end
  end

  // Widen the live set to the helper's fixed digit count.
  always_comb begin
    hex_pad = '0;
    dp_pad  = '0;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      hex_pad[i] = live_hex_q[i];
      dp_pad[i]  = live_dp_q[i];
    end
  end

  assign blank_mask = lzb_mask(hex_pad, dp_pad, N_DIGITS);
  assign sel_blank  = lzb && blank_mask[digit_q];

  hex2sseg u_hex2sseg (
    .hex_i  (sel_hex),
    .dp_i   (~sel_dp),
    .sseg_o (dec_sseg)
  );

  // Next anode/segment pattern; dark everywhere except the show phase.
  always_comb begin
    an_d   = '1;
    sseg_d = SsegOff;
    if (state_q == StShow) begin
      for (int i = 0; i < int'(N_DIGITS); i++) begin
        an_d[i] = (digit_q != DigW'(i));
      end
      sseg_d = sel_blank ? SsegOff : dec_sseg;
    end
  end

  // State, counter and digit registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      digit_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
    end
  end

  // Shadow and live digit registers plus the pending flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_hex_q <= '0;
      shadow_dp_q  <= '0;
      live_hex_q   <= '0;
      live_dp_q    <= '0;
      pending_q    <= 1'b0;
    end else begin
      shadow_hex_q <= shadow_hex_d;
      shadow_dp_q  <= shadow_dp_d;
      live_hex_q   <= live_hex_d;
      live_dp_q    <= live_dp_d;
      pending_q    <= pending_d;
    end
  end

  // Registered display outputs and frame pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an_q   <= '1;
      sseg_q <= SsegOff;
      tick_q <= 1'b0;
    end else begin
      an_q   <= an_d;
      sseg_q <= sseg_d;
      tick_q <= tick_d;
    end
  end

  assign an         = an_q;
  assign sseg       = sseg_q;
  assign frame_tick = tick_q;
  assign pending    = pending_q;

endmodule
